// File: rtl/traffic_pkg.sv
// Shared types and default timing for the traffic controller and its monitor.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_ALLRED  = 3'd0,
    PH_NS_G    = 3'd1,
    PH_NS_Y    = 3'd2,
    PH_EW_G    = 3'd4,
    PH_EW_Y    = 3'd5,
    PH_INVALID = 3'd7
  } phase_e;

  typedef enum logic [3:0] {
    ST_INIT_RED, ST_NS_G, ST_NS_Y, ST_RED_TO_EW, ST_EW_G,
    ST_EW_Y, ST_RED_TO_NS, ST_RESYNC, ST_FAULT
  } mon_state_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_CONFLICT = 3'd1,
    FC_LAMP     = 3'd2,
    FC_SEQUENCE = 3'd3,
    FC_SHORT    = 3'd4,
    FC_LONG     = 3'd5
  } fault_e;

  localparam int DEF_GREEN_TIME      = 60;
  localparam int DEF_YELLOW_TIME     = 4;
  localparam int DEF_RED_TIME        = 3;
  localparam int DEF_SAFE_TIME       = 4;
  localparam int DEF_SAFE_TIME_RESET = 15;
  localparam int DEF_TOL             = 0;

  localparam logic [6:0] CNT_MAX = 7'd127;

  // Lamp phase the monitor expects to see while in a given sequence state.
  function automatic phase_e state_phase(input mon_state_e s);
    case (s)
      ST_INIT_RED, ST_RED_TO_EW, ST_RED_TO_NS: state_phase = PH_ALLRED;
      ST_NS_G: state_phase = PH_NS_G;
      ST_NS_Y: state_phase = PH_NS_Y;
      ST_EW_G: state_phase = PH_EW_G;
      ST_EW_Y: state_phase = PH_EW_Y;
      default: state_phase = PH_INVALID;
    endcase
  endfunction

  function automatic mon_state_e state_next(input mon_state_e s);
    case (s)
      ST_INIT_RED:  state_next = ST_NS_G;
      ST_NS_G:      state_next = ST_NS_Y;
      ST_NS_Y:      state_next = ST_RED_TO_EW;
      ST_RED_TO_EW: state_next = ST_EW_G;
      ST_EW_G:      state_next = ST_EW_Y;
      ST_EW_Y:      state_next = ST_RED_TO_NS;
      ST_RED_TO_NS: state_next = ST_NS_G;
      default:      state_next = s;
    endcase
  endfunction

endpackage

// File: rtl/traffic_lamp_decoder.sv
// Maps the six observed lamps to an intersection phase; flags any direction
// that does not show exactly one lamp.
module traffic_lamp_decoder
  import traffic_pkg::*;
(
  input  logic       ns_green,
  input  logic       ns_yellow,
  input  logic       ns_red,
  input  logic       ew_green,
  input  logic       ew_yellow,
  input  logic       ew_red,
  output logic [2:0] phase,
  output logic       lamp_err
);

  phase_e ph;

  always_comb begin
    lamp_err = !($onehot({ns_green, ns_yellow, ns_red}) &&
                 $onehot({ew_green, ew_yellow, ew_red}));
    ph = PH_INVALID;
    if (!lamp_err) begin
      if (ns_red && ew_red)         ph = PH_ALLRED;
      else if (ew_red && ns_green)  ph = PH_NS_G;
      else if (ew_red && ns_yellow) ph = PH_NS_Y;
      else if (ns_red && ew_green)  ph = PH_EW_G;
      else if (ns_red && ew_yellow) ph = PH_EW_Y;
    end
    phase = ph;
  end

endmodule

// File: rtl/traffic_monitor.sv
// Independent safety monitor: checks lamp sequence, phase durations and
// conflicts, latching the first fault and requesting all-flash.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_TIME      = DEF_GREEN_TIME,
  parameter int YELLOW_TIME     = DEF_YELLOW_TIME,
  parameter int RED_TIME        = DEF_RED_TIME,
  parameter int SAFE_TIME       = DEF_SAFE_TIME,
  parameter int SAFE_TIME_RESET = DEF_SAFE_TIME_RESET,
  parameter int TOL             = DEF_TOL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_green,
  input  logic       ns_yellow,
  input  logic       ns_red,
  input  logic       ew_green,
  input  logic       ew_yellow,
  input  logic       ew_red,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_req,
  output logic [2:0] phase,
  output logic [7:0] cycles_done
);

  mon_state_e state, state_nx;
  logic [6:0] cnt, cnt_nx;
  logic       seen_red, seen_red_nx;
  logic [2:0] dec_phase;
  logic       lamp_err, conflict, cyc_inc, do_clear;
  phase_e     ph;
  fault_e     det;
  int         e_len;

  traffic_lamp_decoder u_dec (
    .ns_green (ns_green),
    .ns_yellow(ns_yellow),
    .ns_red   (ns_red),
    .ew_green (ew_green),
    .ew_yellow(ew_yellow),
    .ew_red   (ew_red),
    .phase    (dec_phase),
    .lamp_err (lamp_err)
  );

  always_comb begin
    ph       = phase_e'(dec_phase);
    conflict = (ns_green | ns_yellow) & (ew_green | ew_yellow);
    case (state)
      ST_INIT_RED:                e_len = SAFE_TIME_RESET;
      ST_NS_G, ST_EW_G:           e_len = GREEN_TIME;
      ST_NS_Y, ST_EW_Y:           e_len = YELLOW_TIME;
      ST_RED_TO_EW, ST_RED_TO_NS: e_len = RED_TIME + SAFE_TIME;
      default:                    e_len = 0;
    endcase

    state_nx    = state;
    cnt_nx      = cnt;
    seen_red_nx = seen_red;
    det         = FC_NONE;
    cyc_inc     = 1'b0;
    do_clear    = 1'b0;

    case (state)
      ST_FAULT: begin
        if (clear_fault) begin
          do_clear    = 1'b1;
          state_nx    = ST_RESYNC;
          seen_red_nx = 1'b0;
          cnt_nx      = 7'd0;
        end
      end
      // Re-acquire the sequence: all-red first, then whichever green shows.
      ST_RESYNC: begin
        if (conflict)                          det = FC_CONFLICT;
        else if (lamp_err)                     det = FC_LAMP;
        else if (ph == PH_ALLRED)              seen_red_nx = 1'b1;
        else if (seen_red && ph == PH_NS_G) begin
          state_nx = ST_NS_G;
          cnt_nx   = 7'd1;
        end else if (seen_red && ph == PH_EW_G) begin
          state_nx = ST_EW_G;
          cnt_nx   = 7'd1;
        end
      end
      default: begin
        if (conflict)      det = FC_CONFLICT;
        else if (lamp_err) det = FC_LAMP;
        else if (ph == state_phase(state)) begin
          if (int'(cnt) >= e_len + TOL) det = FC_LONG;
          else if (cnt != CNT_MAX)      cnt_nx = cnt + 7'd1;
        end else if (ph == state_phase(state_next(state))) begin
          if (int'(cnt) < e_len - TOL) det = FC_SHORT;
          else begin
            state_nx = state_next(state);
            cnt_nx   = 7'd1;
            cyc_inc  = (state == ST_EW_Y);
          end
        end else begin
          det = FC_SEQUENCE;
        end
      end
    endcase

    if (det != FC_NONE) state_nx = ST_FAULT;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT_RED;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 7'd0;
      seen_red    <= 1'b0;
      fault       <= 1'b0;
      flash_req   <= 1'b0;
      fault_code  <= 3'd0;
      phase       <= PH_ALLRED;
      cycles_done <= 8'd0;
    end else begin
      cnt      <= cnt_nx;
      seen_red <= seen_red_nx;
      phase    <= dec_phase;
      if (do_clear) begin
        fault      <= 1'b0;
        flash_req  <= 1'b0;
        fault_code <= 3'd0;
      end else if (det != FC_NONE) begin
        fault      <= 1'b1;
        flash_req  <= 1'b1;
        fault_code <= det;
      end
      if (cyc_inc) cycles_done <= cycles_done + 8'd1;
    end
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor with default timing parameters.
module tb_traffic_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ns_green, ns_yellow, ns_red;
  logic       ew_green, ew_yellow, ew_red;
  logic       clear_fault = 1'b0;
  logic       fault, flash_req;
  logic [2:0] fault_code, phase;
  logic [7:0] cycles_done;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [2:0] LG = 3'b100, LY = 3'b010, LR = 3'b001, LOFF = 3'b000;

  traffic_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .ns_green   (ns_green),
    .ns_yellow  (ns_yellow),
    .ns_red     (ns_red),
    .ew_green   (ew_green),
    .ew_yellow  (ew_yellow),
    .ew_red     (ew_red),
    .clear_fault(clear_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_req  (flash_req),
    .phase      (phase),
    .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  task automatic set_lamps(input logic [2:0] ns, input logic [2:0] ew);
    {ns_green, ns_yellow, ns_red} = ns;
    {ew_green, ew_yellow, ew_red} = ew;
  endtask

  // Lamps change on the falling edge; each rising edge is one sample.
  task automatic hold(input logic [2:0] ns, input logic [2:0] ew, input int n);
    set_lamps(ns, ew);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int f, input int code, input int ph,
                         input int cyc);
    chk({tag, "/fault"}, 32'(fault), f);
    chk({tag, "/flash"}, 32'(flash_req), f);
    chk({tag, "/code"}, 32'(fault_code), code);
    chk({tag, "/phase"}, 32'(phase), ph);
    chk({tag, "/cycles"}, 32'(cycles_done), cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_lamps(LR, LR);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full NS green through EW yellow, ending on the last EW yellow sample.
  task automatic run_cycle();
    hold(LG, LR, 60);
    hold(LY, LR, 4);
    hold(LR, LR, 7);
    hold(LR, LG, 60);
    hold(LR, LY, 4);
  endtask

  initial begin
    set_lamps(LR, LR);
    repeat (2) @(negedge clk);
    chk_out("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // Nominal: ALLRED 1-15, first green 16, EW_Y->ALLRED at 151 and 293.
    hold(LR, LR, 15);
    run_cycle();
    chk_out("nom_ew_y", 0, 0, 5, 0);
    hold(LR, LR, 1);
    chk_out("nom_s151", 0, 0, 0, 1);
    hold(LR, LR, 6);
    run_cycle();
    chk_out("nom_s292", 0, 0, 5, 1);
    hold(LR, LR, 1);
    chk_out("nom_s293", 0, 0, 0, 2);

    // Conflict, then later faults must not overwrite the code.
    do_reset();
    hold(LR, LR, 3);
    hold(LG, LG, 1);
    chk_out("conflict", 1, 1, 7, 0);
    hold(LOFF, LOFF, 2);
    chk_out("conflict_hold", 1, 1, 7, 0);
    hold(LR, LR, 1);
    chk_out("conflict_sticky", 1, 1, 0, 0);

    // Priority: conflict over lamp, lamp over sequence.
    do_reset();
    hold(LR, LR, 3);
    hold(3'b110, LG, 1);
    chk_out("prio_conf_lamp", 1, 1, 7, 0);
    do_reset();
    hold(LR, LR, 3);
    hold(3'b110, LR, 1);
    chk_out("prio_lamp_seq", 1, 2, 7, 0);

    // Initial all-red boundaries.
    do_reset();
    hold(LR, LR, 14);
    hold(LG, LR, 1);
    chk_out("init_short", 1, 4, 1, 0);
    do_reset();
    hold(LR, LR, 15);
    chk_out("init_at_e", 0, 0, 0, 0);
    hold(LR, LR, 1);
    chk_out("init_long", 1, 5, 0, 0);

    // NS green duration boundaries.
    do_reset();
    hold(LR, LR, 15);
    hold(LG, LR, 59);
    hold(LY, LR, 1);
    chk_out("ns_g_short", 1, 4, 2, 0);
    do_reset();
    hold(LR, LR, 15);
    hold(LG, LR, 60);
    chk_out("ns_g_at_e", 0, 0, 1, 0);
    hold(LG, LR, 1);
    chk_out("ns_g_long", 1, 5, 1, 0);

    // NS green again after the inter-phase red skips EW entirely.
    do_reset();
    hold(LR, LR, 15);
    hold(LG, LR, 60);
    hold(LY, LR, 4);
    hold(LR, LR, 7);
    hold(LG, LR, 1);
    chk_out("sequence", 1, 3, 1, 0);

    // Lamp fault, ignored follow-up fault, clear and resync onto EW green.
    do_reset();
    hold(LR, LR, 15);
    hold(LG, LR, 10);
    hold(LOFF, LR, 1);
    chk_out("lamp_dark", 1, 2, 7, 0);
    hold(LG, LG, 1);
    chk_out("lamp_first_kept", 1, 2, 7, 0);
    clear_fault = 1'b1;
    hold(LR, LR, 1);
    clear_fault = 1'b0;
    chk_out("cleared", 0, 0, 0, 0);
    hold(LR, LR, 3);
    hold(LR, LG, 60);
    chk_out("resync_ew_g", 0, 0, 4, 0);
    hold(LR, LY, 4);
    hold(LR, LR, 1);
    chk_out("resync_cycle", 0, 0, 0, 1);

    // clear outside FAULT must not drop into resync: short red still faults.
    clear_fault = 1'b1;
    hold(LR, LR, 1);
    clear_fault = 1'b0;
    chk_out("clear_ignored", 0, 0, 0, 1);
    hold(LR, LR, 1);
    hold(LG, LR, 1);
    chk_out("clear_ign_short", 1, 4, 1, 1);

    // Reset mid EW green overrides a concurrent conflict and clear.
    do_reset();
    hold(LR, LR, 15);
    run_cycle();
    hold(LR, LR, 1);
    chk_out("pre_rst_cycle", 0, 0, 0, 1);
    hold(LR, LR, 6);
    hold(LG, LR, 60);
    hold(LY, LR, 4);
    hold(LR, LR, 7);
    hold(LR, LG, 10);
    chk_out("mid_ew_g", 0, 0, 4, 1);
    reset = 1'b1;
    clear_fault = 1'b1;
    set_lamps(LG, LG);
    @(negedge clk);
    chk_out("mid_reset", 0, 0, 0, 0);
    reset = 1'b0;
    clear_fault = 1'b0;
    hold(LR, LR, 15);
    run_cycle();
    hold(LR, LR, 1);
    chk_out("restart_cycle", 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
